muldiv_sequencer: RTL and testbench
===================================

// Module: muldiv_sequencer
// PURPOSE
//  Execute-stage controller and iterative engine for RV32M MUL/DIV/REM ops.
//  Accepts a request from the execute cycle and holds the pipeline through the
//  hazard unit (StallMD) while a shift-add or restoring-divide sequence runs.
//  Presents a one-cycle result for the execute stage to mux into ALU_ResultM.
// PARAMETERS
//  XLEN  32  operand/result width; iteration count = XLEN
// PORTS
//  clk            in   1     clock, rising edge
//  rst            in   1     asynchronous active-low reset (0 = reset)
//  MulDivE        in   1     execute-stage instruction is an M-extension op
//  MulDivOpE      in   3     funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU,
//                            100 DIV, 101 DIVU, 110 REM, 111 REMU
//  RD1_E          in   XLEN  rs1 operand (forwarded)
//  RD2_E          in   XLEN  rs2 operand (forwarded)
//  FlushE         in   1     execute-stage flush (branch/jump redirect)
//  StallMD        out  1     hold F/D/E stages; combinational
//  MulDivDoneE    out  1     result valid this cycle
//  MulDivResultE  out  XLEN  result, valid only when MulDivDoneE=1
//  BusyMD         out  1     state != IDLE
// BEHAVIOUR
//  States: IDLE, BUSY, DONE. Reset (rst=0, async) -> IDLE, counter=0, all
//   internal regs 0, MulDivDoneE=0, MulDivResultE=0, BusyMD=0.
//  StallMD = MulDivE & ~FlushE & (state != DONE).
//  IDLE: MulDivE=1 & FlushE=0 -> latch op, |RD1|, |RD2| (signed per op), result
//   sign flags; special case -> DONE, else -> BUSY with counter=0.
//  Special cases (no iteration): divisor=0 -> DIV/DIVU quotient all-ones,
//   REM/REMU = rs1; signed overflow (rs1=0x80000000, rs2=-1, DIV/REM) ->
//   quotient 0x80000000, remainder 0.
//  BUSY: one iteration per cycle; counter increments; at counter=XLEN-1 -> DONE.
//   MUL*: 2*XLEN accumulator, add multiplicand if multiplier LSB, shift.
//   DIV*: restoring; shift remainder left, trial subtract, set quotient bit.
//  DONE: MulDivDoneE=1, MulDivResultE driven, StallMD=0; -> IDLE next cycle
//   unconditionally (never restarts on the same, still-present request).
//  Sign fix-up on DONE: product negated (64-bit) if operand signs differ;
//   quotient negated if signs differ; remainder takes sign of dividend.
//   MUL returns low XLEN; MULH/MULHSU/MULHU return high XLEN.
//  Latency: normal op 1 IDLE + XLEN BUSY + 1 DONE = XLEN+2 cycles in E (34);
//   special case 2 cycles. Back-to-back ops: next request accepted in IDLE the
//   cycle after DONE.
//  FlushE=1 in any state -> IDLE next edge, no MulDivDoneE, StallMD=0 same cycle.
//  MulDivE dropping mid-BUSY (no flush) is illegal; engine completes anyway.
//  MulDivResultE holds last value outside DONE; consumers gate with Done.
// TESTING
//  MUL 7 x 0xFFFFFFFD -> Done at cycle 33 after request, result 0xFFFFFFEB,
//   StallMD high cycles 0-32.
//  MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000;
//   MULHSU 0xFFFFFFFF x 2 -> 0xFFFFFFFF.
//  DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD; REM same -> 0xFFFFFFFF; DIVU 100/7 -> 14.
//  DIVU 5 / 0 -> 0xFFFFFFFF and REMU 5/0 -> 5, Done at cycle 1;
//   DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000.
//  FlushE pulse at BUSY counter=10 -> IDLE, Done never asserted; then new
//   MUL 3x4 -> 12 with full latency.
//  rst low mid-BUSY -> immediate IDLE, all outputs 0; two back-to-back DIVU ops
//   both complete, each with correct result and exactly one Done pulse.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide engine for the execute stage.
// Holds F/D/E via StallMD while a shift-add or restoring-divide sequence runs.
module muldiv_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            MulDivE,
  input  logic [2:0]      MulDivOpE,
  input  logic [XLEN-1:0] RD1_E,
  input  logic [XLEN-1:0] RD2_E,
  input  logic            FlushE,
  output logic            StallMD,
  output logic            MulDivDoneE,
  output logic [XLEN-1:0] MulDivResultE,
  output logic            BusyMD
);

  localparam int unsigned CntW = $clog2(XLEN);
  localparam int unsigned AccW = 2 * XLEN;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mdStateT;

  mdStateT         state, nextState;
  logic [2:0]      opReg;
  logic [XLEN-1:0] operand;
  logic [AccW-1:0] acc;
  logic [CntW-1:0] count;
  logic            negRes, negRem;

  logic            isDivE, aSignedE, bSignedE, negAE, negBE;
  logic [XLEN-1:0] absAE, absBE;
  logic            divZeroE, overflowE, specialE, acceptE;
  logic [XLEN-1:0] specialResE;

  logic            lastIter, divOk;
  logic [XLEN:0]   mulSum, divTrial, divDiff;
  logic [AccW-1:0] mulNext, divNext, accNext, prodFixed;
  logic [XLEN-1:0] quoFixed, remFixed, finalRes;

  assign acceptE  = MulDivE & ~FlushE;
  assign lastIter = (count == CntW'(XLEN - 1));

  // Request decode: operand magnitudes, sign flags and no-iteration cases
  always_comb begin
    isDivE      = MulDivOpE[2];
    aSignedE    = MulDivOpE[2] ? ~MulDivOpE[0] : (MulDivOpE[1:0] != 2'b11);
    bSignedE    = MulDivOpE[2] ? ~MulDivOpE[0] : ~MulDivOpE[1];
    negAE       = aSignedE & RD1_E[XLEN-1];
    negBE       = bSignedE & RD2_E[XLEN-1];
    absAE       = negAE ? XLEN'(-RD1_E) : RD1_E;
    absBE       = negBE ? XLEN'(-RD2_E) : RD2_E;
    divZeroE    = isDivE & (RD2_E == '0);
    overflowE   = isDivE & ~MulDivOpE[0] & (RD1_E == {1'b1, {(XLEN-1){1'b0}}})
                  & (RD2_E == '1);
    specialE    = divZeroE | overflowE;
    specialResE = '0;
    if (divZeroE) specialResE = MulDivOpE[1] ? RD1_E : '1;
    else          specialResE = MulDivOpE[1] ? '0 : RD1_E;
  end

  // One iteration: acc = {high/remainder, low/quotient}
  always_comb begin
    mulSum    = {1'b0, acc[AccW-1:XLEN]} + (acc[0] ? {1'b0, operand} : '0);
    mulNext   = {mulSum, acc[XLEN-1:1]};
    divTrial  = acc[AccW-1:XLEN-1];
    divDiff   = divTrial - {1'b0, operand};
    divOk     = ~divDiff[XLEN];
    divNext   = {(divOk ? divDiff[XLEN-1:0] : divTrial[XLEN-1:0]), acc[XLEN-2:0], divOk};
    accNext   = opReg[2] ? divNext : mulNext;
    prodFixed = negRes ? AccW'(-accNext) : accNext;
    quoFixed  = negRes ? XLEN'(-accNext[XLEN-1:0]) : accNext[XLEN-1:0];
    remFixed  = negRem ? XLEN'(-accNext[AccW-1:XLEN]) : accNext[AccW-1:XLEN];
    if (opReg[2])                finalRes = opReg[1] ? remFixed : quoFixed;
    else if (opReg[1:0] == 2'b00) finalRes = prodFixed[XLEN-1:0];
    else                         finalRes = prodFixed[AccW-1:XLEN];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= nextState;
  end

  // Next state and combinational stall; a flush wins in every state
  always_comb begin
    nextState = state;
    StallMD   = MulDivE & ~FlushE & (state != DONE);
    case (state)
      IDLE:    if (acceptE) nextState = specialE ? DONE : BUSY;
      BUSY:    if (lastIter) nextState = DONE;
      DONE:    nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (FlushE) nextState = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opReg         <= '0;
      operand       <= '0;
      acc           <= '0;
      count         <= '0;
      negRes        <= 1'b0;
      negRem        <= 1'b0;
      MulDivDoneE   <= 1'b0;
      MulDivResultE <= '0;
      BusyMD        <= 1'b0;
    end else begin
      MulDivDoneE <= (nextState == DONE);
      BusyMD      <= (nextState != IDLE);
      case (state)
        IDLE: if (acceptE) begin
          opReg   <= MulDivOpE;
          count   <= '0;
          negRes  <= negAE ^ negBE;
          negRem  <= negAE;
          operand <= isDivE ? absBE : absAE;
          acc     <= {{XLEN{1'b0}}, (isDivE ? absAE : absBE)};
          if (specialE) MulDivResultE <= specialResE;
        end
        BUSY: begin
          acc   <= accNext;
          count <= count + CntW'(1);
          if (lastIter && !FlushE) MulDivResultE <= finalRes;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed RV32M vectors, random ops
// against an arithmetic reference model, flush, reset and back-to-back cases.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        MulDivE = 1'b0;
  logic [2:0]  MulDivOpE = 3'd0;
  logic [31:0] RD1_E = 32'd0;
  logic [31:0] RD2_E = 32'd0;
  logic        FlushE = 1'b0;
  logic        StallMD, MulDivDoneE, BusyMD;
  logic [31:0] MulDivResultE;

  int checks = 0;
  int errors = 0;
  int doneSeen = 0;

  muldiv_sequencer #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .MulDivE(MulDivE), .MulDivOpE(MulDivOpE),
    .RD1_E(RD1_E), .RD2_E(RD2_E), .FlushE(FlushE), .StallMD(StallMD),
    .MulDivDoneE(MulDivDoneE), .MulDivResultE(MulDivResultE), .BusyMD(BusyMD)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (MulDivDoneE) doneSeen++;

  // RV32M semantics with wide arithmetic
  function automatic logic [31:0] refRes(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] ax, bx, p;
    int sa, sb;
    logic [31:0] r;
    ax = (op == 3'd3) ? {32'd0, a} : {{32{a[31]}}, a};
    bx = (op == 3'd2 || op == 3'd3) ? {32'd0, b} : {{32{b[31]}}, b};
    p  = ax * bx;
    sa = a;
    sb = b;
    case (op)
      3'd0:    r = p[31:0];
      3'd1, 3'd2, 3'd3: r = p[63:32];
      3'd4:    r = (b == 0) ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? a : 32'(sa / sb);
      3'd5:    r = (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6:    r = (b == 0) ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
      default: r = (b == 0) ? a : a % b;
    endcase
    return r;
  endfunction

  function automatic int refLat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
    return 33;
  endfunction

  // Issue one request; report result, Done cycle (request cycle = 0) and stall anomalies
  task automatic runOp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input bit keep, output logic [31:0] res, output int lat, output int stallBad);
    @(posedge clk); #1;
    MulDivE = 1'b1; MulDivOpE = op; RD1_E = a; RD2_E = b;
    lat = -1; stallBad = 0; res = 32'hDEADBEEF;
    for (int c = 0; c < 100 && lat < 0; c++) begin
      @(negedge clk);
      if (MulDivDoneE) begin
        lat = c; res = MulDivResultE;
        if (StallMD !== 1'b0) stallBad++;
      end else if (StallMD !== 1'b1) stallBad++;
    end
    if (!keep) MulDivE = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({MulDivDoneE, BusyMD, StallMD} !== 3'b000 || MulDivResultE !== 32'd0) begin
      errors++;
      $display("FAIL reset_outputs: got done=%b busy=%b stall=%b res=%h expected 0 0 0 00000000",
               MulDivDoneE, BusyMD, StallMD, MulDivResultE);
    end
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0]  tOp[11]  = '{3'd0, 3'd3, 3'd1, 3'd2, 3'd4, 3'd6, 3'd5, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] tA[11]   = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9,
                              32'hFFFFFFF9, 32'd100, 32'd5, 32'd5, 32'h80000000, 32'h80000000};
    logic [31:0] tB[11]   = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                              32'd7, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] tExp[11] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFD,
                              32'hFFFFFFFF, 32'd14, 32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
    int          tLat[11] = '{33, 33, 33, 33, 33, 33, 33, 1, 1, 1, 1};
    logic [31:0] res;
    int lat, sb;
    for (int i = 0; i < 11; i++) begin
      runOp(tOp[i], tA[i], tB[i], 1'b0, res, lat, sb);
      checks++;
      if (res !== tExp[i]) begin
        errors++;
        $display("FAIL directed_result[%0d]: got %h expected %h", i, res, tExp[i]);
      end
      checks++;
      if (lat !== tLat[i]) begin
        errors++;
        $display("FAIL directed_latency[%0d]: got %0d expected %0d", i, lat, tLat[i]);
      end
      checks++;
      if (sb !== 0) begin
        errors++;
        $display("FAIL directed_stall[%0d]: got %0d bad cycles expected 0", i, sb);
      end
    end
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a, b, res;
    int lat, sb, mode;
    for (int i = 0; i < 24; i++) begin
      op = 3'($urandom_range(0, 7));
      a = $urandom; b = $urandom;
      mode = $urandom_range(0, 7);
      if (mode == 0) b = 32'd0;
      else if (mode == 1) begin a = 32'h80000000; b = 32'hFFFFFFFF; end
      else if (mode == 2) b = 32'($urandom_range(1, 15));
      else if (mode == 3) a = 32'($urandom_range(0, 1000));
      runOp(op, a, b, 1'b0, res, lat, sb);
      checks++;
      if (res !== refRes(op, a, b) || lat !== refLat(op, a, b) || sb !== 0) begin
        errors++;
        $display("FAIL random[%0d] op=%0d a=%h b=%h: got %h lat %0d stallbad %0d expected %h lat %0d stallbad 0",
                 i, op, a, b, res, lat, sb, refRes(op, a, b), refLat(op, a, b));
      end
    end
  endtask

  task automatic test_flush();
    logic [31:0] res;
    int lat, sb, d0;
    @(posedge clk); #1;
    MulDivE = 1'b1; MulDivOpE = 3'd0; RD1_E = 32'd5; RD2_E = 32'd9;
    repeat (11) @(posedge clk);
    #1;
    checks++;
    if (BusyMD !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy_before: got %b expected 1", BusyMD);
    end
    d0 = doneSeen;
    FlushE = 1'b1;
    #1;
    checks++;
    if (StallMD !== 1'b0) begin
      errors++;
      $display("FAIL flush_stall: got %b expected 0", StallMD);
    end
    @(posedge clk); #1;
    FlushE = 1'b0; MulDivE = 1'b0;
    checks++;
    if (BusyMD !== 1'b0) begin
      errors++;
      $display("FAIL flush_busy_after: got %b expected 0", BusyMD);
    end
    repeat (40) @(posedge clk);
    checks++;
    if (doneSeen !== d0) begin
      errors++;
      $display("FAIL flush_no_done: got %0d done pulses expected 0", doneSeen - d0);
    end
    runOp(3'd0, 32'd3, 32'd4, 1'b0, res, lat, sb);
    checks++;
    if (res !== 32'd12 || lat !== 33) begin
      errors++;
      $display("FAIL flush_then_mul: got %h lat %0d expected 0000000c lat 33", res, lat);
    end
  endtask

  task automatic test_reset_midbusy();
    @(posedge clk); #1;
    MulDivE = 1'b1; MulDivOpE = 3'd5; RD1_E = 32'd1000; RD2_E = 32'd3;
    repeat (10) @(posedge clk);
    #1;
    MulDivE = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if ({MulDivDoneE, BusyMD, StallMD} !== 3'b000 || MulDivResultE !== 32'd0) begin
      errors++;
      $display("FAIL reset_midbusy: got done=%b busy=%b stall=%b res=%h expected 0 0 0 00000000",
               MulDivDoneE, BusyMD, StallMD, MulDivResultE);
    end
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_back_to_back();
    logic [31:0] r1, r2;
    int l1, l2, s1, s2, d0;
    d0 = doneSeen;
    runOp(3'd5, 32'd1000, 32'd3, 1'b1, r1, l1, s1);
    runOp(3'd5, 32'hFFFFFFFF, 32'd16, 1'b0, r2, l2, s2);
    repeat (3) @(posedge clk);
    checks++;
    if (r1 !== 32'd333 || l1 !== 33) begin
      errors++;
      $display("FAIL b2b_first: got %h lat %0d expected 0000014d lat 33", r1, l1);
    end
    checks++;
    if (r2 !== 32'h0FFFFFFF || l2 !== 33) begin
      errors++;
      $display("FAIL b2b_second: got %h lat %0d expected 0fffffff lat 33", r2, l2);
    end
    checks++;
    if (doneSeen - d0 !== 2) begin
      errors++;
      $display("FAIL b2b_done_pulses: got %0d expected 2", doneSeen - d0);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_flush();
    test_reset_midbusy();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
